// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier that borrows the shared 32-bit
// execute-stage ALU to produce the low 32 bits of a 32x32 product.
// A request is captured in IDLE. RUN performs one add-and-shift step per cycle
// through the ALU. DONE holds the result on a valid/ready response channel.
// Optional feature macro: ALU_MUL_SEQ_EARLY_EXIT_EN. When it is defined, RUN
// ends as soon as the remaining multiplier bits are all zero.

`timescale 1ns/1ps

module alu_mul_seq #(
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        alu_sel,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_c
);

    // ADD encoding of the shared ALU opcode space (matches ALU_ADD in defines.vh)
    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        mcand_q, mcand_d;
    logic [31:0]        mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cntLast;
    logic               mplierZero;

    assign cntLast    = (cnt_q == {CNT_W{1'b1}});
    assign mplierZero = (mplier_q == 32'd0);

    // State register; reset discards any in-flight multiply
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in RUN, wait for consumer in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                if (mplierZero || cntLast) begin
                    state_d = DONE;
                end
`else
                if (cntLast) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: operands, partial product accumulator and step counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Datapath next values: load at accept, then add-and-shift each RUN cycle
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    acc_d    = 32'd0;
                    mcand_d  = req_a;
                    mplier_d = req_b;
                    cnt_d    = '0;
                end
            end
            RUN: begin
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
                if (!mplierZero) begin
                    acc_d = alu_c;
                end
`else
                acc_d = alu_c;
`endif
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
            end
        endcase
    end

    // Outputs: ALU operands only while RUN owns the ALU, result only in DONE
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'd0;
        alu_sel    = 1'b0;
        alu_op     = ALU_ADD;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            RUN: begin
                alu_sel = 1'b1;
                alu_a   = acc_q;
                alu_b   = mplier_q[0] ? mcand_q : 32'd0;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_data  = acc_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq. It models the shared ALU as a
// combinational adder and checks results, latencies, ALU ownership,
// backpressure and mid-run reset against hand-computed values.
// Expected RUN lengths follow ALU_MUL_SEQ_EARLY_EXIT_EN when it is defined.

`timescale 1ns/1ps

module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        alu_sel;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_c;

    int vectors = 0;
    int errors  = 0;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    localparam int RUN_7X6   = 4;
    localparam int RUN_FXF   = 32;
    localparam int RUN_8X2   = 3;
    localparam int RUN_1X10  = 6;
    localparam int RUN_5X3   = 3;
    localparam int RUN_BZERO = 1;
    localparam int RUN_BMSB  = 32;
    localparam int RUN_9X11  = 5;
`else
    localparam int RUN_7X6   = 32;
    localparam int RUN_FXF   = 32;
    localparam int RUN_8X2   = 32;
    localparam int RUN_1X10  = 32;
    localparam int RUN_5X3   = 32;
    localparam int RUN_BZERO = 32;
    localparam int RUN_BMSB  = 32;
    localparam int RUN_9X11  = 32;
`endif

    alu_mul_seq #(.CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_sel    (alu_sel),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c)
    );

    // Shared ALU stand-in: combinational add, carry-out dropped
    assign alu_c = alu_a + alu_b;

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
        checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, "_resp_data"},  resp_data,           32'd0);
        checkOutput({tag, "_alu_sel"},    {31'd0, alu_sel},    32'd0);
        checkOutput({tag, "_alu_op"},     {28'd0, alu_op},     32'd0);
        checkOutput({tag, "_alu_a"},      alu_a,               32'd0);
        checkOutput({tag, "_alu_b"},      alu_b,               32'd0);
    endtask

    // Present one request for a single cycle, then scramble the operand inputs
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b);
        checkOutput({tag, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'hDEAD_BEEF;
    endtask

    // Step until resp_valid (bounded), checking RUN length, ALU ownership and data
    task automatic waitResp(input string tag, input int expRun, input logic [31:0] expData, input int already);
        int n    = already;
        int sel  = already;
        bit opOk = 1'b1;
        while (!resp_valid && n < 40) begin
            if (alu_sel) sel++;
            if (alu_op !== 4'h0) opOk = 1'b0;
            tick();
            n++;
        end
        checkOutput({tag, "_run_cycles"},   32'(n),              32'(expRun));
        checkOutput({tag, "_alu_sel_cyc"},  32'(sel),            32'(expRun));
        checkOutput({tag, "_alu_op_add"},   {31'd0, opOk},       32'd1);
        checkOutput({tag, "_resp_valid"},   {31'd0, resp_valid}, 32'd1);
        checkOutput({tag, "_resp_data"},    resp_data,           expData);
        checkOutput({tag, "_done_alu_sel"}, {31'd0, alu_sel},    32'd0);
        checkOutput({tag, "_done_alu_b"},   alu_b,               32'd0);
    endtask

    // Complete the response handshake and confirm return to IDLE
    task automatic finishResp(input string tag);
        resp_ready = 1'b1;
        tick();
        checkOutput({tag, "_req_ready_after"},  {31'd0, req_ready},  32'd1);
        checkOutput({tag, "_resp_valid_after"}, {31'd0, resp_valid}, 32'd0);
    endtask

    // Directed sequence
    initial begin
        int seen;

        rst_n = 1'b0;
        tick();
        tick();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick();
        checkResetOutputs("idle");

        applyStimulus("m7x6", 32'd7, 32'd6);
        checkOutput("m7x6_c1_alu_sel", {31'd0, alu_sel}, 32'd1);
        checkOutput("m7x6_c1_alu_a",   alu_a,            32'd0);
        checkOutput("m7x6_c1_alu_b",   alu_b,            32'd0);
        checkOutput("m7x6_c1_req_rdy", {31'd0, req_ready}, 32'd0);
        tick();
        checkOutput("m7x6_c2_alu_a",   alu_a,            32'd0);
        checkOutput("m7x6_c2_alu_b",   alu_b,            32'd14);
        tick();
        checkOutput("m7x6_c3_alu_a",   alu_a,            32'd14);
        checkOutput("m7x6_c3_alu_b",   alu_b,            32'd28);
        waitResp("m7x6", RUN_7X6, 32'd42, 2);
        finishResp("m7x6");

        applyStimulus("mFxF", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitResp("mFxF", RUN_FXF, 32'h0000_0001, 0);
        finishResp("mFxF");

        applyStimulus("m8x2", 32'h8000_0000, 32'd2);
        waitResp("m8x2", RUN_8X2, 32'd0, 0);
        finishResp("m8x2");

        applyStimulus("m1x10", 32'h1234_5678, 32'h10);
        waitResp("m1x10", RUN_1X10, 32'h2345_6780, 0);
        finishResp("m1x10");

        applyStimulus("m5x3", 32'd5, 32'd3);
        waitResp("m5x3", RUN_5X3, 32'd15, 0);
        finishResp("m5x3");

        applyStimulus("mBzero", 32'hCAFE_F00D, 32'd0);
        waitResp("mBzero", RUN_BZERO, 32'd0, 0);
        finishResp("mBzero");

        applyStimulus("mBmsb", 32'd1, 32'h8000_0000);
        waitResp("mBmsb", RUN_BMSB, 32'h8000_0000, 0);
        finishResp("mBmsb");

        resp_ready = 1'b0;
        applyStimulus("bp", 32'd9, 32'd11);
        waitResp("bp", RUN_9X11, 32'd99, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                req_valid = 1'b1;
                req_a     = 32'd1;
                req_b     = 32'd1;
            end else begin
                req_valid = 1'b0;
            end
            tick();
            checkOutput("bp_hold_data",  resp_data,           32'd99);
            checkOutput("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("bp_hold_rdy",   {31'd0, req_ready},  32'd0);
        end
        req_valid = 1'b0;
        finishResp("bp");
        tick();
        checkOutput("bp_no_stale_start", {31'd0, alu_sel},   32'd0);
        checkOutput("bp_still_idle",     {31'd0, req_ready}, 32'd1);

        applyStimulus("rst", 32'd3, 32'h8000_0001);
        for (int i = 1; i < 15; i++) tick();
        checkOutput("rst_c15_alu_sel", {31'd0, alu_sel}, 32'd1);
        rst_n = 1'b0;
        tick();
        checkResetOutputs("rst_mid_run");
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid || alu_sel) seen++;
        end
        checkOutput("rst_no_resp", 32'(seen), 32'd0);

        applyStimulus("post", 32'd7, 32'd6);
        waitResp("post", RUN_7X6, 32'd42, 0);
        finishResp("post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
